mul_issue_ctrl: RTL

Issue/writeback controller for the 2-cycle Booth/Wallace multiplier in the EXE stage. It accepts MUL.W / MULH.W / MULH.WU requests through a valid/ready handshake and drives the multiplier's A, B and mul_signed inputs. It tracks the single in-flight operation in the multiplier's internal register, which has no enable. It also selects the 32-bit result half and holds the result in a skid register when the consumer back-pressures, so no result is lost or reordered.

---
 rtl/mul_issue_ctrl.sv | 87 ++++++++
 1 files changed

// File: rtl/mul_issue_ctrl.sv
// Issue/writeback controller for the 2-cycle multiplier: drives operands,
// tracks the single in-flight op and holds its result when the consumer stalls.
module mul_issue_ctrl #(
  parameter int unsigned TAG_W = 5
) (
  input  logic             mul_clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_src1,
  input  logic [31:0]      in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      mul_A,
  output logic [31:0]      mul_B,
  output logic             mul_signed,
  input  logic [63:0]      mul_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [1:0] OP_MULH  = 2'b01;
  localparam logic [1:0] OP_MULHU = 2'b10;

  logic             s1_valid;
  logic             s1_hi;
  logic [TAG_W-1:0] s1_tag;
  logic             hold_valid;
  logic [31:0]      hold_data;
  logic [TAG_W-1:0] hold_tag;

  logic             fire_in;
  logic [31:0]      sel;

  assign mul_A = in_src1;
  assign mul_B = in_src2;

  // Handshake and result steering; everything is forced quiet while in reset.
  always_comb begin
    in_ready   = ~reset & ~flush & ~hold_valid & (~s1_valid | out_ready);
    fire_in    = in_valid & in_ready;
    mul_signed = (in_op != OP_MULHU);
    sel        = s1_hi ? mul_result[63:32] : mul_result[31:0];
    out_valid  = ~reset & (hold_valid | s1_valid);
    out_data   = '0;
    out_tag    = '0;
    if (!reset) begin
      out_data = hold_valid ? hold_data : sel;
      out_tag  = hold_valid ? hold_tag  : s1_tag;
    end
  end

  // The product register has no enable, so a stalled result must be captured now.
  always_ff @(posedge mul_clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_hi      <= 1'b0;
      s1_tag     <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_tag   <= '0;
    end else if (flush) begin
      s1_valid   <= 1'b0;
      hold_valid <= 1'b0;
    end else begin
      s1_valid <= fire_in;
      if (fire_in) begin
        s1_hi  <= (in_op == OP_MULH) | (in_op == OP_MULHU);
        s1_tag <= in_tag;
      end
      if (s1_valid && !hold_valid && !out_ready) begin
        hold_valid <= 1'b1;
        hold_data  <= sel;
        hold_tag   <= s1_tag;
      end else if (hold_valid && out_ready) begin
        hold_valid <= 1'b0;
      end
    end
  end

  a_no_double_occupancy: assert property (
    @(posedge mul_clk) disable iff (reset) !(hold_valid && s1_valid));

endmodule
